// File: rtl/coherence_pkg.sv
// Shared types and helpers for the two-cache coherence bus controller.
package coherence_pkg;

   localparam int NCPU      = 2;
   localparam int WORD_W    = 32;
   localparam int BLK_OFF_W = 3;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic              cpuid_t;

   typedef enum logic [2:0] {
      IDLE,
      SNOOP,
      LD1,
      LD2,
      WB1,
      WB2,
      FWD1,
      FWD2
   } bus_state_t;

   // Word address of one word inside the 2-word block containing addr.
   function automatic word_t blkaddr(input word_t addr, input logic word);
      return {addr[WORD_W-1:BLK_OFF_W], word, 2'b00};
   endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-side and memory-side signals of the coherence bus.
interface coherence_bus_ctrl_if;
   import coherence_pkg::*;

   logic [NCPU-1:0]  dREN;
   logic [NCPU-1:0]  dWEN;
   word_t [NCPU-1:0] daddr;
   word_t [NCPU-1:0] dstore;
   logic [NCPU-1:0]  cctrans;
   logic [NCPU-1:0]  ccwrite;
   logic [NCPU-1:0]  dwait;
   word_t [NCPU-1:0] dload;
   logic [NCPU-1:0]  ccwait;
   logic [NCPU-1:0]  ccinv;
   word_t [NCPU-1:0] ccsnoopaddr;

   logic  mem_ren;
   logic  mem_wen;
   word_t mem_addr;
   word_t mem_wdata;
   word_t mem_rdata;
   logic  mem_ready;

   modport master (
      input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, mem_rdata, mem_ready,
      output dwait, dload, ccwait, ccinv, ccsnoopaddr,
             mem_ren, mem_wen, mem_addr, mem_wdata
   );

   modport slave (
      output dREN, dWEN, daddr, dstore, cctrans, ccwrite, mem_rdata, mem_ready,
      input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
             mem_ren, mem_wen, mem_addr, mem_wdata
   );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves past the winner when a grant is taken.
module rr_arbiter
   import coherence_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt,
   output cpuid_t     gnt_id,
   output logic       gnt_valid
);

   cpuid_t rr_ptr;

   // Pick the pointed-to requester first, otherwise the other one.
   always_comb begin
      gnt_id    = rr_ptr;
      gnt_valid = |req;
      if (!req[rr_ptr]) begin
         gnt_id = ~rr_ptr;
      end
      gnt = gnt_valid ? (2'b01 << gnt_id) : 2'b00;
   end

   // Pointer update: the loser of this grant gets priority next time.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= 1'b0;
      end else if (take && gnt_valid) begin
         rr_ptr <= ~gnt_id;
      end
   end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shared-bus controller: arbitrates two dcaches, snoops the other cache and routes
// 2-word block loads, writebacks and cache-to-cache forwards to a single-port memory.
//
// state | meaning
// IDLE  | no transaction; arbitrate dREN|dWEN
// SNOOP | snoop the other cache, decide forward vs memory load
// LD1   | memory read of block word 0 to requester
// LD2   | memory read of block word 1 to requester
// WB1   | requester writes first word to memory
// WB2   | requester writes second word to memory
// FWD1  | snooper word 0 goes to memory and requester
// FWD2  | snooper word 1 goes to memory and requester
module coherence_bus_ctrl
   import coherence_pkg::*;
(
   input logic                  CLK,
   input logic                  RST,
   coherence_bus_ctrl_if.master bus
);

   bus_state_t state, next_state;
   cpuid_t     req_id, next_req_id;
   cpuid_t     oth;
   logic [1:0] gnt;
   cpuid_t     gnt_id;
   logic       gnt_valid;
   logic       take;
   logic       unused_cctrans;

   assign unused_cctrans = ^bus.cctrans;
   assign take           = (state == IDLE);
   assign oth            = ~req_id;

   rr_arbiter u_arb (
      .CLK       (CLK),
      .RST       (RST),
      .req       (bus.dREN | bus.dWEN),
      .take      (take),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   // State and granted-requester registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         req_id <= 1'b0;
      end else begin
         state  <= next_state;
         req_id <= next_req_id;
      end
   end

   // Next-state decode and all bus/memory outputs.
   always_comb begin
      next_state      = state;
      next_req_id     = req_id;
      bus.dwait       = '1;
      bus.dload       = '0;
      bus.ccwait      = '0;
      bus.ccinv       = '0;
      bus.ccsnoopaddr = '0;
      bus.mem_ren     = 1'b0;
      bus.mem_wen     = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               next_req_id = gnt_id;
               next_state  = (|(gnt & bus.dWEN)) ? WB1 : SNOOP;
            end
         end
         SNOOP: begin
            bus.ccwait[oth]      = 1'b1;
            bus.ccsnoopaddr[oth] = blkaddr(bus.daddr[req_id], 1'b0);
            bus.ccinv[oth]       = bus.ccwrite[req_id];
            next_state           = bus.ccwrite[oth] ? FWD1 : LD1;
         end
         LD1, LD2: begin
            bus.mem_ren          = 1'b1;
            bus.mem_addr         = blkaddr(bus.daddr[req_id], state == LD2);
            bus.dload[req_id]    = bus.mem_rdata;
            bus.dwait[req_id]    = ~bus.mem_ready;
            if (bus.mem_ready) begin
               next_state = (state == LD1) ? LD2 : IDLE;
            end
         end
         WB1, WB2: begin
            bus.mem_wen          = 1'b1;
            bus.mem_addr         = bus.daddr[req_id];
            bus.mem_wdata        = bus.dstore[req_id];
            bus.dwait[req_id]    = ~bus.mem_ready;
            if (bus.mem_ready) begin
               next_state = (state == WB1) ? WB2 : IDLE;
            end
         end
         FWD1, FWD2: begin
            bus.ccwait[oth]      = 1'b1;
            bus.ccsnoopaddr[oth] = blkaddr(bus.daddr[req_id], 1'b0);
            bus.ccinv[oth]       = bus.ccwrite[req_id];
            // Wait for the snooper to present its dirty word before touching memory.
            if (bus.dWEN[oth]) begin
               bus.mem_wen       = 1'b1;
               bus.mem_addr      = bus.daddr[oth];
               bus.mem_wdata     = bus.dstore[oth];
               bus.dload[req_id] = bus.dstore[oth];
               bus.dwait[req_id] = ~bus.mem_ready;
               bus.dwait[oth]    = ~bus.mem_ready;
               if (bus.mem_ready) begin
                  next_state = (state == FWD1) ? FWD2 : IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
